// File: rtl/parallel_cmd_mux.sv
// Command/response sequencer between the Pi parallel byte link and NUM_CH sample channels.
// Decodes strobed command bytes and returns a snapshotted sample one byte per strobe, LSB first.
module parallel_cmd_mux #(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned SAMPLE_W   = 16,
   parameter logic [7:0]  CMD_BASE   = 8'h78,
   parameter logic [7:0]  STATUS_CMD = 8'h3F,
   parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       bus_strobe,
   input  logic                       bus_cs_n,
   input  logic [7:0]                 cmd_byte,
   input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]          ch_valid,
   output logic [7:0]                 resp_byte,
   output logic [2:0]                 channel_sel,
   output logic                       busy,
   output logic [NUM_CH-1:0]          fresh,
   output logic [7:0]                 err_count
);

   localparam int unsigned NBYTES = (SAMPLE_W + 7) / 8;
   localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
   localparam int unsigned SNAP_W = NBYTES * 8;

   typedef enum logic {StIdle, StSend} state_t;

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [SNAP_W-1:0]   snap;
   logic                strobe_s1, strobe_s2, strobe_s3;
   logic                cs_s1, cs_s2;

   logic                bus_event;
   logic [7:0]          cmd_off;
   logic                is_ch;
   logic                ch_accept;
   logic [SNAP_W-1:0]   sel_snap;
   logic [NUM_CH-1:0]   clr_mask;
   logic [NUM_CH-1:0]   fresh_d;
   logic [7:0]          send_byte;
   logic [7:0]          status_byte;

   assign bus_event = strobe_s2 & ~strobe_s3 & ~cs_s2;
   assign cmd_off   = cmd_byte - CMD_BASE;
   // 9-bit compare so CMD_BASE+NUM_CH may exceed 255 without wrapping.
   assign is_ch     = ({1'b0, cmd_byte} >= {1'b0, CMD_BASE}) &&
                      ({1'b0, cmd_byte} < ({1'b0, CMD_BASE} + 9'(NUM_CH)));
   assign ch_accept = bus_event && (state == StIdle) && is_ch;

   always_comb begin
      sel_snap = '0;
      clr_mask = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cmd_off == 8'(k)) begin
            sel_snap[SAMPLE_W-1:0] = ch_data[k*SAMPLE_W +: SAMPLE_W];
            clr_mask[k]            = 1'b1;
         end
      end
   end

   always_comb begin
      send_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == IDX_W'(i)) send_byte = snap[i*8 +: 8];
      end
   end

   always_comb begin
      status_byte               = '0;
      status_byte[NUM_CH-1:0]   = fresh;
   end

   // A new sample arriving in the same cycle as its read keeps the flag set.
   assign fresh_d = (fresh & ~(ch_accept ? clr_mask : '0)) | ch_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= StIdle;
         idx         <= '0;
         snap        <= '0;
         strobe_s1   <= 1'b0;
         strobe_s2   <= 1'b0;
         strobe_s3   <= 1'b0;
         cs_s1       <= 1'b0;
         cs_s2       <= 1'b0;
         resp_byte   <= '0;
         channel_sel <= '0;
         busy        <= 1'b0;
         fresh       <= '0;
         err_count   <= '0;
      end else begin
         strobe_s1 <= bus_strobe;
         strobe_s2 <= strobe_s1;
         strobe_s3 <= strobe_s2;
         cs_s1     <= bus_cs_n;
         cs_s2     <= cs_s1;
         fresh     <= fresh_d;

         case (state)
            StIdle: begin
               if (bus_event) begin
                  if (is_ch) begin
                     snap        <= sel_snap;
                     channel_sel <= cmd_off[2:0];
                     resp_byte   <= sel_snap[7:0];
                     if (NBYTES > 1) begin
                        idx   <= IDX_W'(1);
                        busy  <= 1'b1;
                        state <= StSend;
                     end
                  end else if (cmd_byte == STATUS_CMD) begin
                     resp_byte <= status_byte;
                  end else begin
                     resp_byte <= ERR_BYTE;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
            end
            StSend: begin
               // Deselect mid-reply abandons the reply; resp_byte and idx are left as-is.
               if (cs_s2) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (bus_event) begin
                  resp_byte <= send_byte;
                  idx       <= idx + IDX_W'(1);
                  if (idx == IDX_W'(NBYTES - 1)) begin
                     busy  <= 1'b0;
                     state <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
